// File: rtl/div_ratio_checker_pkg.sv
// Shared types, defaults and helpers for the divided-clock ratio checker.
package div_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED
  } chk_state_t;

  localparam int DIV_RATIO_DEF  = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int LOCK_COUNT_DEF = 4;

  // A period is good when its length matches the ratio and it was high for
  // exactly half of it (rounded down).
  function automatic logic is_good(input logic [31:0] cnt,
                                   input logic [31:0] hcnt,
                                   input logic [31:0] ratio);
    return (cnt == ratio) && (hcnt == (ratio >> 1));
  endfunction

endpackage

// File: rtl/div_ratio_checker_sync_2ff.sv
// Single-bit two-stage synchronizer, synchronous active-high reset.
module sync_2ff (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the input through two flops; reset clears both stages.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage takes the other's pre-edge value.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/div_ratio_checker.sv
// Checks that a divided clock, sampled as data, toggles at the expected
// period and duty; reports each period and qualifies the clock with locked.
module div_ratio_checker
  import div_chk_pkg::*;
#(
  parameter int DIV_RATIO  = DIV_RATIO_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             ratio_err,
  output logic             locked
);

  localparam int               GW        = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0]    LOCK_FULL = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  chk_state_t       state_q, state_d;
  logic [GW-1:0]    good_cnt, good_d;
  logic [CNT_W-1:0] cnt, hcnt;
  logic             s1, s2;
  logic             rise, good, timeout;
  logic             capture, err;

  sync_2ff u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (div_clk),
    .q      (s1)
  );

  assign rise    = s1 & ~s2;
  assign good    = is_good(32'(cnt), 32'(hcnt), 32'(DIV_RATIO));
  // A rise in the same cycle as saturation is evaluated as a normal period.
  assign timeout = (cnt == CNT_MAX) && !rise;

  // Next state, lock-run counter and the capture / error pulses.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d = state_q;
    good_d  = good_cnt;
    capture = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE:    if (enable) state_d = ACQUIRE;
      ACQUIRE: if (rise) state_d = MEASURE;
      MEASURE, LOCKED: begin
        if (rise) begin
          capture = 1'b1;
          if (!good) begin
            err     = 1'b1;
            good_d  = '0;
            state_d = MEASURE;
          end else if (state_q == MEASURE) begin
            if (good_cnt == LOCK_LAST) begin
              good_d  = LOCK_FULL;
              state_d = LOCKED;
            end else begin
              good_d = good_cnt + GW'(1);
            end
          end
        end else if (timeout) begin
          err     = 1'b1;
          good_d  = '0;
          state_d = ACQUIRE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable abandons everything, including a pulse due this edge.
    if (!enable) begin
      state_d = IDLE;
      good_d  = '0;
      capture = 1'b0;
      err     = 1'b0;
    end
  end

  // State, lock-run counter and the registered status outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      good_cnt     <= '0;
      period_valid <= 1'b0;
      ratio_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt     <= good_d;
      period_valid <= capture;
      ratio_err    <= err;
      locked       <= (state_d == LOCKED);
    end
  end

  // Edge-detect register, saturating period/high counters and captured results.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s2        <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
    end else begin
      s2 <= s1;
      if (state_d == IDLE) begin
        cnt       <= '0;
        hcnt      <= '0;
        period    <= '0;
        high_time <= '0;
      end else begin
        if (capture) begin
          period    <= cnt;
          high_time <= hcnt;
        end
        if (rise) begin
          cnt  <= CNT_ONE;
          hcnt <= CNT_ONE;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          if (hcnt != CNT_MAX) hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s1};
        end
      end
    end
  end

endmodule
